// File: rtl/hazard_unit.sv
// Pipeline hazard controller: resolves overflow, branch/jump and load-use
// conditions into stall/flush controls, and counts stall and flush cycles.
module hazard_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  IF_ID_OP1,
    input  logic [3:0]  IF_ID_OP2,
    input  logic [3:0]  ID_EX_OP1,
    input  logic        MEM_WRITE,
    input  logic        OVER_FLOW,
    input  logic        BRANCH_JUMP_FLAG,
    output logic        IF_ID_WRITE,
    output logic        IF_ID_FLASH,
    output logic        ID_HAZARD_FLASH,
    output logic        EX_FLASH,
    output logic        PC_WRITE,
    output logic [15:0] STALL_COUNT,
    output logic [15:0] FLUSH_COUNT
);

    typedef enum logic [1:0] {
        SEL_NORMAL,
        SEL_LOAD_USE,
        SEL_BRANCH,
        SEL_OVERFLOW
    } sel_e;

    sel_e        sel;
    logic        load_use;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    assign load_use = MEM_WRITE &
                      ((ID_EX_OP1 == IF_ID_OP1) | (ID_EX_OP1 == IF_ID_OP2));

    // Only the highest-priority active condition reaches the outputs.
    always_comb begin
        sel = SEL_NORMAL;
        if (OVER_FLOW)
            sel = SEL_OVERFLOW;
        else if (BRANCH_JUMP_FLAG)
            sel = SEL_BRANCH;
        else if (load_use)
            sel = SEL_LOAD_USE;
    end

    always_comb begin
        IF_ID_WRITE     = 1'b1;
        IF_ID_FLASH     = 1'b0;
        ID_HAZARD_FLASH = 1'b0;
        EX_FLASH        = 1'b0;
        PC_WRITE        = 1'b1;
        unique case (sel)
            SEL_OVERFLOW: begin
                IF_ID_FLASH     = 1'b1;
                ID_HAZARD_FLASH = 1'b1;
                EX_FLASH        = 1'b1;
            end
            SEL_BRANCH: begin
                IF_ID_FLASH = 1'b1;
            end
            SEL_LOAD_USE: begin
                IF_ID_WRITE     = 1'b0;
                PC_WRITE        = 1'b0;
                ID_HAZARD_FLASH = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Saturating event counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (sel == SEL_LOAD_USE && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
        if ((sel == SEL_OVERFLOW || sel == SEL_BRANCH) && flush_q != 16'hFFFF)
            flush_d = flush_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign STALL_COUNT = stall_q;
    assign FLUSH_COUNT = flush_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: control outputs checked inline,
// counter values checked through an expected-value scoreboard.
module tb_hazard_unit;

    logic        CLK;
    logic        RST;
    logic [3:0]  IF_ID_OP1, IF_ID_OP2, ID_EX_OP1;
    logic        MEM_WRITE, OVER_FLOW, BRANCH_JUMP_FLAG;
    logic        IF_ID_WRITE, IF_ID_FLASH, ID_HAZARD_FLASH, EX_FLASH, PC_WRITE;
    logic [15:0] STALL_COUNT, FLUSH_COUNT;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] stall;
        logic [15:0] flush;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_stall, m_flush;

    hazard_unit dut (
        .CLK              (CLK),
        .RST              (RST),
        .IF_ID_OP1        (IF_ID_OP1),
        .IF_ID_OP2        (IF_ID_OP2),
        .ID_EX_OP1        (ID_EX_OP1),
        .MEM_WRITE        (MEM_WRITE),
        .OVER_FLOW        (OVER_FLOW),
        .BRANCH_JUMP_FLAG (BRANCH_JUMP_FLAG),
        .IF_ID_WRITE      (IF_ID_WRITE),
        .IF_ID_FLASH      (IF_ID_FLASH),
        .ID_HAZARD_FLASH  (ID_HAZARD_FLASH),
        .EX_FLASH         (EX_FLASH),
        .PC_WRITE         (PC_WRITE),
        .STALL_COUNT      (STALL_COUNT),
        .FLUSH_COUNT      (FLUSH_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    wire [4:0] ctrl = {IF_ID_WRITE, IF_ID_FLASH, ID_HAZARD_FLASH, EX_FLASH, PC_WRITE};

    // Scoreboard consumer: counters are compared just after each edge.
    always @(posedge CLK) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (STALL_COUNT !== e.stall || FLUSH_COUNT !== e.flush) begin
                n_bad++;
                $display("FAIL %s counters: got stall=%h flush=%h, expected stall=%h flush=%h",
                         e.name, STALL_COUNT, FLUSH_COUNT, e.stall, e.flush);
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic mw, input logic ov, input logic bj);
        IF_ID_OP1 = a; IF_ID_OP2 = b; ID_EX_OP1 = c;
        MEM_WRITE = mw; OVER_FLOW = ov; BRANCH_JUMP_FLAG = bj;
    endtask

    // Advance the model by one edge and queue the counter values expected after it.
    task automatic predict(input logic rst, input logic stall_ev, input logic flush_ev,
                           input string name);
        exp_t e;
        if (rst) begin
            m_stall = 16'd0;
            m_flush = 16'd0;
        end else begin
            if (stall_ev && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (flush_ev && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end
        e.stall = m_stall; e.flush = m_flush; e.name = name;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (ctrl !== 5'b11111) begin
            n_bad++;
            $display("FAIL reset_ctrl_ovf: got %b expected %b", ctrl, 5'b11111);
        end
        predict(1'b1, 1'b0, 1'b0, "reset");
        @(posedge CLK); #2;
        RST = 1'b0;
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        predict(1'b0, 1'b0, 1'b0, "reset_idle");
        @(posedge CLK); #2;
    endtask

    task automatic test_directed();
        // a, b, c, mw, ov, bj, expected ctrl, stall event, flush event
        logic [3:0] ta[10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd5, 4'd3, 4'd0, 4'd7, 4'd2};
        logic [3:0] tb[10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd9, 4'd4, 4'd0, 4'd8, 4'd6};
        logic [3:0] tc[10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd5, 4'd3, 4'd0, 4'd9, 4'd6};
        logic       tm[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       to[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       tj[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [4:0] te[10] = '{5'b10001, 5'b11001, 5'b11111, 5'b00100, 5'b00100,
                               5'b11001, 5'b11111, 5'b00100, 5'b10001, 5'b10001};
        logic       ts[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       tf[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(ta[i], tb[i], tc[i], tm[i], to[i], tj[i]);
            #1;
            n_cmp++;
            if (ctrl !== te[i]) begin
                n_bad++;
                $display("FAIL directed_%0d ctrl: got %b expected %b", i, ctrl, te[i]);
            end
            predict(1'b0, ts[i], tf[i], $sformatf("directed_%0d", i));
            @(posedge CLK); #2;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] a, b, c;
            logic mw, ov, bj, lu;
            logic [4:0] exp_c;
            a = 4'($urandom_range(0, 3)); b = 4'($urandom_range(0, 3));
            c = 4'($urandom_range(0, 3));
            mw = 1'($urandom_range(0, 1));
            ov = ($urandom_range(0, 5) == 0);
            bj = ($urandom_range(0, 3) == 0);
            lu = mw && (c == a || c == b);
            exp_c = ov ? 5'b11111 : bj ? 5'b11001 : lu ? 5'b00100 : 5'b10001;
            drive(a, b, c, mw, ov, bj);
            #1;
            n_cmp++;
            if (ctrl !== exp_c) begin
                n_bad++;
                $display("FAIL b2b_%0d ctrl: got %b expected %b (a=%0d b=%0d c=%0d mw=%b ov=%b bj=%b)",
                         i, ctrl, exp_c, a, b, c, mw, ov, bj);
            end
            predict(1'b0, lu && !ov && !bj, ov || bj, $sformatf("b2b_%0d", i));
            @(posedge CLK); #2;
        end
    endtask

    task automatic test_saturation();
        drive(4'd4, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 65537; i++) begin
            predict(1'b0, 1'b1, 1'b0, "sat_hold");
            @(posedge CLK); #2;
        end
        n_cmp++;
        if (STALL_COUNT !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_stall: got %h expected ffff", STALL_COUNT);
        end
        // Reset wins over a pending load-use increment.
        RST = 1'b1;
        #1;
        n_cmp++;
        if (ctrl !== 5'b00100) begin
            n_bad++;
            $display("FAIL reset_ctrl_lu: got %b expected %b", ctrl, 5'b00100);
        end
        predict(1'b1, 1'b1, 1'b0, "sat_reset");
        @(posedge CLK); #2;
        RST = 1'b0;
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        predict(1'b0, 1'b0, 1'b0, "post_reset");
        @(posedge CLK); #2;
    endtask

    initial begin
        RST = 1'b1;
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        m_stall = 16'd0;
        m_flush = 16'd0;
        @(posedge CLK); #2;
        test_reset();
        test_directed();
        test_back_to_back();
        test_saturation();
        @(posedge CLK); #3;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
